// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM states, word-length and parity-select encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Parity select, indexed by {sp, eps}
    localparam logic [1:0] PAR_ODD   = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        logic [7:0] m;
        case (wls)
            WLS_5:   m = 8'h1F;
            WLS_6:   m = 8'h3F;
            WLS_7:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic expected_parity(input logic [7:0] data, input logic sp,
                                             input logic eps);
        logic p;
        case ({sp, eps})
            PAR_ODD:  p = ~^data;
            PAR_EVEN: p = ^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Received-character bus from the UART receiver to the RBR / RX FIFO.
interface uart_receiver_if;
    logic       rsr_load;
    logic [7:0] rx_data;
    logic       pe;
    logic       fe;
    logic       bi;

    modport master (output rsr_load, rx_data, pe, fe, bi);
    modport slave  (input  rsr_load, rx_data, pe, fe, bi);
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial input; resets to the idle-high level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic preset,
    input  logic urrst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sync_q <= '1;
        end else if (urrst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled start detect, 5-8 bit LSB-first deserialise, parity/stop/break check.
// Character and status are registered and presented with a one-cycle rsr_load strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  urrst,
    input  logic                  receive_edge,
    input  logic                  uart_rxd,
    input  logic                  loop,
    input  logic                  loop_txd,
    input  logic                  pen,
    input  logic                  eps,
    input  logic                  sp,
    input  logic                  stb,
    input  logic [1:0]            wls,
    output logic                  receive_clk_clr,
    output logic                  rx_busy,
    uart_receiver_if.master       rx
);

    localparam int            CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    rx_state_e     state, state_nxt;
    logic          rxd_sel, rxd_s, rxd_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    data_m;
    logic          rx_parity;
    logic          mid_tick, full_tick, last_bit;
    logic          take_data, take_par, do_load;
    logic          unused_stb;

    // Only the first stop bit is ever checked, so the stop-bit count is irrelevant here.
    assign unused_stb = stb;

    assign rxd_sel = loop ? loop_txd : uart_rxd;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .pclk   (pclk),
        .preset (preset),
        .urrst  (urrst),
        .din    (rxd_sel),
        .dout   (rxd_s)
    );

    assign mid_tick  = receive_edge && (cnt == CNT_MID);
    assign full_tick = receive_edge && (cnt == CNT_LAST);
    // >= rather than == so a live wls change mid-frame can never strand the FSM in DATA
    assign last_bit  = bit_cnt >= (3'd4 + {1'b0, wls});

    always_comb begin
        state_nxt       = state;
        receive_clk_clr = 1'b0;
        take_data       = 1'b0;
        take_par        = 1'b0;
        do_load         = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    state_nxt       = START;
                    receive_clk_clr = 1'b1;
                end
            end
            START: begin
                if (mid_tick) begin
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    take_data = 1'b1;
                    if (last_bit) begin
                        state_nxt = pen ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (full_tick) begin
                    take_par  = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    do_load   = 1'b1;
                    state_nxt = rxd_s ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else if (urrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rxd_prev  <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_parity <= 1'b0;
        end else if (urrst) begin
            rxd_prev  <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_parity <= 1'b0;
        end else begin
            rxd_prev <= rxd_s;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (receive_edge) begin
                cnt <= cnt + 1'b1;
            end
            if (state == START) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (take_data) begin
                shreg[bit_cnt] <= rxd_s;
                bit_cnt        <= bit_cnt + 1'b1;
            end
            if (take_par) begin
                rx_parity <= rxd_s;
            end
        end
    end

    assign data_m = shreg & wls_mask(wls);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx.rsr_load <= 1'b0;
            rx.rx_data  <= '0;
            rx.pe       <= 1'b0;
            rx.fe       <= 1'b0;
            rx.bi       <= 1'b0;
        end else if (urrst) begin
            rx.rsr_load <= 1'b0;
            rx.rx_data  <= '0;
            rx.pe       <= 1'b0;
            rx.fe       <= 1'b0;
            rx.bi       <= 1'b0;
        end else begin
            rx.rsr_load <= do_load;
            if (do_load) begin
                rx.rx_data <= data_m;
                rx.pe      <= pen & (rx_parity != expected_parity(data_m, sp, eps));
                rx.fe      <= ~rxd_s;
                rx.bi      <= (data_m == 8'h00) & (~pen | ~rx_parity) & ~rxd_s;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed frames into uart_receiver; expected characters are queued at send time and checked by a monitor.
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       pclk;
    logic       preset;
    logic       urrst;
    logic       receive_edge;
    logic       uart_rxd;
    logic       loop;
    logic       loop_txd;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       stb;
    logic [1:0] wls;
    logic       receive_clk_clr;
    logic       rx_busy;

    uart_receiver_if rx_if ();

    uart_receiver dut (
        .pclk            (pclk),
        .preset          (preset),
        .urrst           (urrst),
        .receive_edge    (receive_edge),
        .uart_rxd        (uart_rxd),
        .loop            (loop),
        .loop_txd        (loop_txd),
        .pen             (pen),
        .eps             (eps),
        .sp              (sp),
        .stb             (stb),
        .wls             (wls),
        .receive_clk_clr (receive_clk_clr),
        .rx_busy         (rx_busy),
        .rx              (rx_if)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   div   = 0;
    bit   tick_en  = 1'b0;
    bit   use_loop = 1'b0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // 16x tick every 4 pclk; the phase is re-aligned whenever the receiver asks for it
    initial begin
        receive_edge = 1'b0;
        forever begin
            @(negedge pclk);
            if (receive_clk_clr) div = 0;
            else                 div = (div + 1) % 4;
            receive_edge = tick_en && (div == 3);
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int guard;
        repeat (n) begin
            guard = 0;
            @(posedge pclk);
            while (!receive_edge && guard < 20) begin
                @(posedge pclk);
                guard++;
            end
        end
        @(negedge pclk);
    endtask

    task automatic drive(input logic b);
        if (use_loop) loop_txd = b;
        else          uart_rxd = b;
    endtask

    task automatic expect_char(input logic [7:0] d, input logic p, input logic f, input logic b);
        sb.push_back({d, p, f, b});
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit with_par,
                              input logic par, input logic stop);
        drive(1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive(d[i]);
            wait_ticks(16);
        end
        if (with_par) begin
            drive(par);
            wait_ticks(16);
        end
        drive(stop);
        wait_ticks(16);
        drive(1'b1);
        wait_ticks(16);
    endtask

    always @(negedge pclk) begin
        if (!preset && rx_if.rsr_load) begin
            if (sb.size() == 0) begin
                check1("unexpected_rsr_load", rx_if.rsr_load, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check8("rx_data", rx_if.rx_data, mon_e.data);
                check1("pe", rx_if.pe, mon_e.pe);
                check1("fe", rx_if.fe, mon_e.fe);
                check1("bi", rx_if.bi, mon_e.bi);
            end
        end
    end

    initial begin
        preset   = 1'b1;
        urrst    = 1'b0;
        uart_rxd = 1'b1;
        loop     = 1'b0;
        loop_txd = 1'b1;
        pen      = 1'b0;
        eps      = 1'b0;
        sp       = 1'b0;
        stb      = 1'b0;
        wls      = 2'b11;
        repeat (3) @(negedge pclk);
        check1("rst_rsr_load", rx_if.rsr_load, 1'b0);
        check8("rst_rx_data", rx_if.rx_data, 8'h00);
        check1("rst_pe", rx_if.pe, 1'b0);
        check1("rst_fe", rx_if.fe, 1'b0);
        check1("rst_bi", rx_if.bi, 1'b0);
        check1("rst_rx_busy", rx_busy, 1'b0);
        check1("rst_clk_clr", receive_clk_clr, 1'b0);
        preset  = 1'b0;
        tick_en = 1'b1;
        wait_ticks(20);

        // 8N1 0xA5
        expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);

        // 7E1 0x35: four ones, correct even parity bit is 0
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        expect_char(8'h35, 1'b0, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
        expect_char(8'h35, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);

        // 5-bit framing error, then line released
        wls = 2'b00; pen = 1'b0; eps = 1'b0;
        expect_char(8'h1F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
        check1("fe_back_idle", rx_busy, 1'b0);
        check1("fe_held", rx_if.fe, 1'b1);

        // Break: line low for three 8N1 frame times gives one character only
        wls = 2'b11;
        expect_char(8'h00, 1'b0, 1'b1, 1'b1);
        drive(1'b0);
        wait_ticks(480);
        check1("brk_wait_busy", rx_busy, 1'b1);
        drive(1'b1);
        wait_ticks(32);
        check1("brk_released_idle", rx_busy, 1'b0);

        // 4-tick glitch is a false start
        drive(1'b0);
        wait_ticks(4);
        drive(1'b1);
        wait_ticks(2);
        check1("glitch_in_start", rx_busy, 1'b1);
        wait_ticks(16);
        check1("glitch_back_idle", rx_busy, 1'b0);

        // Loopback 8O1 0x5A with the pin held low; odd parity bit is 1
        loop_txd = 1'b1;
        loop     = 1'b1;
        use_loop = 1'b1;
        uart_rxd = 1'b0;
        pen = 1'b1; eps = 1'b0; sp = 1'b0;
        wait_ticks(8);
        expect_char(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1);
        check8("loop_data_held", rx_if.rx_data, 8'h5A);

        // Soft reset in the middle of DATA
        drive(1'b0);
        wait_ticks(16);
        drive(1'b1);
        wait_ticks(16);
        drive(1'b0);
        wait_ticks(16);
        check1("urrst_pre_busy", rx_busy, 1'b1);
        drive(1'b1);
        urrst = 1'b1;
        @(negedge pclk);
        urrst = 1'b0;
        check1("urrst_rx_busy", rx_busy, 1'b0);
        check1("urrst_rsr_load", rx_if.rsr_load, 1'b0);
        check8("urrst_rx_data", rx_if.rx_data, 8'h00);
        check1("urrst_pe", rx_if.pe, 1'b0);
        check1("urrst_fe", rx_if.fe, 1'b0);
        check1("urrst_bi", rx_if.bi, 1'b0);
        wait_ticks(200);
        check1("urrst_stays_idle", rx_busy, 1'b0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drained: %0d characters outstanding, 0 required", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
